// File: rtl/selec_perfil_arb.sv
// Profile-channel arbiter: picks one owner among eligible channels (lowest index wins),
// with a minimum hold window, optional pre-emption, and a registered code to the decoder.
module selec_perfil_arb #(
  parameter int NUM_CH   = 2,
  parameter int CODE_W   = 3,
  parameter int MIN_HOLD = 4,
  parameter int PREEMPT  = 1,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        on,
  input  logic [NUM_CH-1:0]        atv_PRIO,
  input  logic [NUM_CH*CODE_W-1:0] code_in,
  output logic [CODE_W-1:0]        out,
  output logic                     valid,
  output logic [IDX_W-1:0]         owner,
  output logic                     switch_pulse
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(MIN_HOLD);

  state_t              state, state_n;
  logic [NUM_CH-1:0]   elig;
  logic [IDX_W-1:0]    cand;
  logic [CODE_W-1:0]   cand_code;
  logic                any_elig;
  logic                owner_elig;
  logic [CODE_W-1:0]   owner_code;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CODE_W-1:0]   out_n;
  logic                valid_n;
  logic [IDX_W-1:0]    owner_n;
  logic                pulse_n;

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    elig      = on & atv_PRIO;
    cand      = '0;
    cand_code = '0;
    any_elig  = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (elig[i-1]) begin
        cand      = IDX_W'(i - 1);
        cand_code = code_in[(i-1)*CODE_W +: CODE_W];
        any_elig  = 1'b1;
      end
    end
  end

  always_comb begin
    owner_elig = 1'b0;
    owner_code = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_elig = elig[i];
        owner_code = code_in[i*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    state_n = state;
    out_n   = out;
    valid_n = valid;
    owner_n = owner;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    unique case (state)
      IDLE: begin
        out_n   = '0;
        valid_n = 1'b0;
        owner_n = '0;
        if (any_elig) begin
          state_n = OWNED;
          owner_n = cand;
          out_n   = cand_code;
          valid_n = 1'b1;
          pulse_n = 1'b1;
          cnt_n   = HOLD_LD;
        end
      end
      OWNED: begin
        if (!owner_elig) begin
          if (any_elig) begin
            owner_n = cand;
            out_n   = cand_code;
            pulse_n = 1'b1;
            cnt_n   = HOLD_LD;
          end else begin
            state_n = IDLE;
            out_n   = '0;
            valid_n = 1'b0;
            owner_n = '0;
            cnt_n   = '0;
          end
        end else if ((PREEMPT != 0) && (cand < owner) && (cnt == '0)) begin
          owner_n = cand;
          out_n   = cand_code;
          pulse_n = 1'b1;
          cnt_n   = HOLD_LD;
        end else begin
          out_n = owner_code;
          cnt_n = (cnt != '0) ? cnt - 1'b1 : '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out          <= '0;
      valid        <= 1'b0;
      owner        <= '0;
      switch_pulse <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      out          <= out_n;
      valid        <= valid_n;
      owner        <= owner_n;
      switch_pulse <= pulse_n;
      cnt          <= cnt_n;
    end
  end

endmodule

// File: tb/tb_selec_perfil_arb.sv
// Directed bench for selec_perfil_arb: one pre-empting and one non-pre-empting instance
// share the stimulus; expected outputs are queued at drive time and checked after the edge.
module tb_selec_perfil_arb;

  typedef struct packed {
    logic [2:0] code;
    logic       vld;
    logic       own;
    logic       pls;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] on, atv_PRIO;
  logic [5:0] code_in;
  logic [2:0] out_a, out_b;
  logic       valid_a, valid_b, owner_a, owner_b, pulse_a, pulse_b;

  exp_t qa[$], qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  selec_perfil_arb #(.NUM_CH(2), .CODE_W(3), .MIN_HOLD(4), .PREEMPT(1)) dut_a (
    .clk(clk), .rst(rst), .on(on), .atv_PRIO(atv_PRIO), .code_in(code_in),
    .out(out_a), .valid(valid_a), .owner(owner_a), .switch_pulse(pulse_a)
  );

  selec_perfil_arb #(.NUM_CH(2), .CODE_W(3), .MIN_HOLD(4), .PREEMPT(0)) dut_b (
    .clk(clk), .rst(rst), .on(on), .atv_PRIO(atv_PRIO), .code_in(code_in),
    .out(out_b), .valid(valid_b), .owner(owner_b), .switch_pulse(pulse_b)
  );

  function automatic exp_t e(input logic [2:0] c, input logic v, input logic o, input logic p);
    exp_t r;
    r.code = c; r.vld = v; r.own = o; r.pls = p;
    return r;
  endfunction

  task automatic step(input string tag, input logic r, input logic [1:0] o, input logic [1:0] a,
                      input logic [2:0] c0, input logic [2:0] c1, input exp_t ea, input exp_t eb);
    exp_t xa, xb, oa, ob;
    rst = r; on = o; atv_PRIO = a; code_in = {c1, c0};
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    #1;
    oa = e(out_a, valid_a, owner_a, pulse_a);
    ob = e(out_b, valid_b, owner_b, pulse_b);
    checks++;
    if (qa.size() == 0) xa = ~oa; else xa = qa.pop_front();
    assert (oa === xa) else begin
      errors++;
      $error("FAIL %s/pre obs=%b exp=%b", tag, oa, xa);
    end
    checks++;
    if (qb.size() == 0) xb = ~ob; else xb = qb.pop_front();
    assert (ob === xb) else begin
      errors++;
      $error("FAIL %s/nopre obs=%b exp=%b", tag, ob, xb);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; on = '0; atv_PRIO = '0; code_in = '0;
    @(negedge clk);
    // reset with everything eligible
    step("rst0", 1, 2'b11, 2'b11, 3'b010, 3'b101, e(3'b000,0,0,0), e(3'b000,0,0,0));
    step("rst1", 1, 2'b11, 2'b11, 3'b010, 3'b101, e(3'b000,0,0,0), e(3'b000,0,0,0));
    step("first", 0, 2'b11, 2'b11, 3'b010, 3'b101, e(3'b010,1,0,1), e(3'b010,1,0,1));
    step("firsth", 0, 2'b11, 2'b11, 3'b010, 3'b101, e(3'b010,1,0,0), e(3'b010,1,0,0));
    // sole owner drops atv_PRIO -> idle, no pulse
    step("idle", 0, 2'b11, 2'b00, 3'b010, 3'b101, e(3'b000,0,0,0), e(3'b000,0,0,0));
    // single grant of ch1
    step("g1", 0, 2'b10, 2'b10, 3'b010, 3'b101, e(3'b101,1,1,1), e(3'b101,1,1,1));
    // ch1 code change and ch0 eligible during hold
    step("h4", 0, 2'b11, 2'b11, 3'b010, 3'b011, e(3'b011,1,1,0), e(3'b011,1,1,0));
    step("h3", 0, 2'b11, 2'b11, 3'b010, 3'b011, e(3'b011,1,1,0), e(3'b011,1,1,0));
    step("h2", 0, 2'b11, 2'b11, 3'b010, 3'b011, e(3'b011,1,1,0), e(3'b011,1,1,0));
    step("h1", 0, 2'b11, 2'b11, 3'b010, 3'b011, e(3'b011,1,1,0), e(3'b011,1,1,0));
    step("preempt", 0, 2'b11, 2'b11, 3'b010, 3'b011, e(3'b010,1,0,1), e(3'b011,1,1,0));
    for (int i = 0; i < 20; i++)
      step("keep", 0, 2'b11, 2'b11, 3'b010, 3'b011, e(3'b010,1,0,0), e(3'b011,1,1,0));
    // ch1 drops on: pre-empting instance already on ch0, the other switches now
    step("drop1", 0, 2'b01, 2'b11, 3'b010, 3'b011, e(3'b010,1,0,0), e(3'b010,1,0,1));
    // ch0 goes away, ch1 back: release switch in both
    step("to1", 0, 2'b10, 2'b10, 3'b010, 3'b110, e(3'b110,1,1,1), e(3'b110,1,1,1));
    step("hold3", 0, 2'b10, 2'b10, 3'b010, 3'b110, e(3'b110,1,1,0), e(3'b110,1,1,0));
    // owner release coincides with ch0 rising, counter still 3
    step("simul", 0, 2'b01, 2'b01, 3'b111, 3'b110, e(3'b111,1,0,1), e(3'b111,1,0,1));
    step("simulh", 0, 2'b01, 2'b01, 3'b111, 3'b110, e(3'b111,1,0,0), e(3'b111,1,0,0));
    step("rstmid", 1, 2'b01, 2'b01, 3'b111, 3'b110, e(3'b000,0,0,0), e(3'b000,0,0,0));
    step("regrant", 0, 2'b01, 2'b01, 3'b100, 3'b110, e(3'b100,1,0,1), e(3'b100,1,0,1));
    step("regranth", 0, 2'b01, 2'b01, 3'b100, 3'b110, e(3'b100,1,0,0), e(3'b100,1,0,0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
